// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - request op encodings (req_op)
//   - sequencer state enum
//   - lane-select widths and request classification helpers
package lsu_pkg;

   localparam logic [2:0] OP_LB  = 3'd0;
   localparam logic [2:0] OP_LH  = 3'd1;
   localparam logic [2:0] OP_LW  = 3'd2;
   localparam logic [2:0] OP_LBU = 3'd3;
   localparam logic [2:0] OP_LHU = 3'd4;
   localparam logic [2:0] OP_SB  = 3'd5;
   localparam logic [2:0] OP_SH  = 3'd6;
   localparam logic [2:0] OP_SW  = 3'd7;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned HALF_W = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ST_RD,
      S_ST_WR,
      S_ERR
   } lsu_state_e;

   // Loads occupy the contiguous low end of the encoding.
   function automatic logic is_load(input logic [2:0] op);
      return (op <= OP_LHU);
   endfunction

   function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lo);
      logic res;
      res = 1'b0;
      unique case (op)
         OP_LH, OP_LHU, OP_SH: res = lo[0];
         OP_LW, OP_SW:         res = (lo != 2'b00);
         default:              res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/load_store_unit_lane.sv
// lsu_byte_lane: combinational byte/halfword lane logic.
//   op_i          request op (lsu_pkg encoding)
//   addr_lo_i     byte address bits [1:0]
//   rdata_i       word read from memory
//   wdata_i       store data (low halfword is all SB/SH need)
//   load_data_o   lane extracted and sign/zero extended for loads
//   merge_data_o  rdata_i with the store lane replaced (SB/SH)
// Halfword lanes use addr_lo_i[1] only, so a halfword address with bit 0
// set selects the enclosing aligned halfword.
module lsu_byte_lane
   import lsu_pkg::*;
(
   input  logic [2:0]  op_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] rdata_i,
   input  logic [15:0] wdata_i,
   output logic [31:0] load_data_o,
   output logic [31:0] merge_data_o
);

   logic [BYTE_W-1:0] byte_sel;
   logic [HALF_W-1:0] half_sel;

   always_comb begin
      byte_sel = rdata_i[7:0];
      unique case (addr_lo_i)
         2'd0: byte_sel = rdata_i[7:0];
         2'd1: byte_sel = rdata_i[15:8];
         2'd2: byte_sel = rdata_i[23:16];
         2'd3: byte_sel = rdata_i[31:24];
      endcase
      half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   always_comb begin
      load_data_o = rdata_i;
      unique case (op_i)
         OP_LB:   load_data_o = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  load_data_o = {24'd0, byte_sel};
         OP_LH:   load_data_o = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  load_data_o = {16'd0, half_sel};
         default: load_data_o = rdata_i;
      endcase
   end

   always_comb begin
      merge_data_o = rdata_i;
      if (op_i == OP_SB) begin
         unique case (addr_lo_i)
            2'd0: merge_data_o[7:0]   = wdata_i[7:0];
            2'd1: merge_data_o[15:8]  = wdata_i[7:0];
            2'd2: merge_data_o[23:16] = wdata_i[7:0];
            2'd3: merge_data_o[31:24] = wdata_i[7:0];
         endcase
      end else if (addr_lo_i[1]) begin
         merge_data_o[31:16] = wdata_i;
      end else begin
         merge_data_o[15:0] = wdata_i;
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage access sequencer in front of a word-addressed
// data memory. Byte/halfword stores become read-modify-write accesses; loads
// return sign/zero-extended lane data.
//   clk, reset             clock, asynchronous active-high reset
//   req_valid/req_ready    request handshake (ready only in IDLE)
//   req_op/addr/wdata      request fields
//   resp_valid             one-cycle completion pulse
//   resp_rdata/resp_err    load data / misalignment flag, held until next response
//   mem_read/mem_write     memory strobes, decoded from state
//   address/write_data     word-aligned memory address and write word
//   read_data              combinational memory read word
module load_store_unit
   import lsu_pkg::*;
#(
   parameter bit CHECK_ALIGN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] address,
   output logic [31:0] write_data,
   input  logic [31:0] read_data
);

   lsu_state_e  state_q;
   logic [2:0]  op_q;
   logic [31:0] addr_q;
   logic [15:0] wdata_q;
   logic [31:0] wbuf_q;
   logic        resp_valid_q;
   logic        resp_err_q;
   logic [31:0] resp_rdata_q;

   logic [31:0] load_data_d;
   logic [31:0] merge_data_d;

   lsu_byte_lane u_lane (
      .op_i         (op_q),
      .addr_lo_i    (addr_q[1:0]),
      .rdata_i      (read_data),
      .wdata_i      (wdata_q),
      .load_data_o  (load_data_d),
      .merge_data_o (merge_data_d)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         op_q         <= OP_LB;
         addr_q       <= '0;
         wdata_q      <= '0;
         wbuf_q       <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         resp_valid_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  op_q    <= req_op;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata[15:0];
                  if (CHECK_ALIGN && is_misaligned(req_op, req_addr[1:0])) begin
                     state_q <= S_ERR;
                  end else if (is_load(req_op)) begin
                     state_q <= S_LOAD;
                  end else if (req_op == OP_SW) begin
                     wbuf_q  <= req_wdata;
                     state_q <= S_ST_WR;
                  end else begin
                     state_q <= S_ST_RD;
                  end
               end
            end
            S_LOAD: begin
               resp_valid_q <= 1'b1;
               resp_err_q   <= 1'b0;
               resp_rdata_q <= load_data_d;
               state_q      <= S_IDLE;
            end
            S_ST_RD: begin
               wbuf_q  <= merge_data_d;
               state_q <= S_ST_WR;
            end
            S_ST_WR: begin
               resp_valid_q <= 1'b1;
               resp_err_q   <= 1'b0;
               resp_rdata_q <= '0;
               state_q      <= S_IDLE;
            end
            S_ERR: begin
               resp_valid_q <= 1'b1;
               resp_err_q   <= 1'b1;
               resp_rdata_q <= '0;
               state_q      <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Strobes come straight from state so an asynchronous reset removes
   // mem_write before the next edge can commit a partial store.
   assign req_ready  = (state_q == S_IDLE);
   assign mem_read   = (state_q == S_LOAD) || (state_q == S_ST_RD);
   assign mem_write  = (state_q == S_ST_WR);
   assign address    = {addr_q[31:2], 2'b00};
   assign write_data = wbuf_q;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic [2:0]  req_op = 3'd0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;

   logic        req_ready_a, resp_valid_a, resp_err_a, mem_read_a, mem_write_a;
   logic [31:0] resp_rdata_a, address_a, write_data_a, read_data_a;
   logic        req_ready_b, resp_valid_b, resp_err_b, mem_read_b, mem_write_b;
   logic [31:0] resp_rdata_b, address_b, write_data_b, read_data_b;

   logic [31:0] mem_a [0:255];
   logic [31:0] mem_b [0:255];

   int errors = 0;
   int checks = 0;
   int lat;
   logic saw_rd, saw_wr;

   always #5 clk = ~clk;

   // DUT with alignment checking
   load_store_unit #(.CHECK_ALIGN(1'b1)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_a),
      .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid_a), .resp_rdata(resp_rdata_a), .resp_err(resp_err_a),
      .mem_read(mem_read_a), .mem_write(mem_write_a), .address(address_a),
      .write_data(write_data_a), .read_data(read_data_a)
   );

   // DUT with alignment checking disabled, same request stream
   load_store_unit #(.CHECK_ALIGN(1'b0)) dut_na (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_b),
      .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b), .resp_err(resp_err_b),
      .mem_read(mem_read_b), .mem_write(mem_write_b), .address(address_b),
      .write_data(write_data_b), .read_data(read_data_b)
   );

   assign read_data_a = mem_a[address_a[9:2]];
   assign read_data_b = mem_b[address_b[9:2]];

   always @(posedge clk) begin
      if (mem_write_a) mem_a[address_a[9:2]] <= write_data_a;
      if (mem_write_b) mem_b[address_b[9:2]] <= write_data_b;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one request, wait (bounded) for the response of the checked DUT.
   // lat = edges after the accept edge before resp_valid is seen.
   task automatic run_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
      @(negedge clk);
      req_op = op; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0; saw_rd = 1'b0; saw_wr = 1'b0;
      while (lat < 10) begin
         @(negedge clk);
         saw_rd = saw_rd | mem_read_a;
         saw_wr = saw_wr | mem_write_a;
         if (resp_valid_a) break;
         @(posedge clk);
         lat++;
      end
   endtask

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      chk("rst_resp_valid", {31'd0, resp_valid_a}, 32'd0);
      chk("rst_resp_err",   {31'd0, resp_err_a},   32'd0);
      chk("rst_resp_rdata", resp_rdata_a, 32'd0);
      chk("rst_address",    address_a,    32'd0);
      chk("rst_write_data", write_data_a, 32'd0);
      chk("rst_mem_read",   {31'd0, mem_read_a},  32'd0);
      chk("rst_mem_write",  {31'd0, mem_write_a}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_req_ready",  {31'd0, req_ready_a}, 32'd1);

      // preload through word stores: word 25 = 14, word 26 = 5
      run_req(3'd7, 32'd100, 32'd14);
      chk("sw_lat", lat, 32'd1);
      chk("sw_rdata", resp_rdata_a, 32'd0);
      chk("sw_mem25", mem_a[25], 32'd14);
      run_req(3'd7, 32'h68, 32'h5);
      chk("sw_mem26", mem_a[26], 32'h5);

      // LW
      run_req(3'd2, 32'd100, 32'd0);
      chk("lw_lat", lat, 32'd1);
      chk("lw_rdata", resp_rdata_a, 32'h0000000E);
      chk("lw_err", {31'd0, resp_err_a}, 32'd0);
      chk("lw_no_write", {31'd0, saw_wr}, 32'd0);

      // SB read-modify-write
      run_req(3'd5, 32'h69, 32'hFFFFFFAB);
      chk("sb_lat", lat, 32'd2);
      chk("sb_did_read", {31'd0, saw_rd}, 32'd1);
      chk("sb_did_write", {31'd0, saw_wr}, 32'd1);
      chk("sb_mem26", mem_a[26], 32'h0000AB05);
      chk("sb_rdata", resp_rdata_a, 32'd0);

      // lane extraction
      run_req(3'd0, 32'h69, 32'd0);
      chk("lb_69", resp_rdata_a, 32'hFFFFFFAB);
      run_req(3'd3, 32'h69, 32'd0);
      chk("lbu_69", resp_rdata_a, 32'h000000AB);
      run_req(3'd4, 32'h68, 32'd0);
      chk("lhu_68", resp_rdata_a, 32'h0000AB05);
      run_req(3'd1, 32'h68, 32'd0);
      chk("lh_68", resp_rdata_a, 32'hFFFFAB05);
      run_req(3'd0, 32'h68, 32'd0);
      chk("lb_68", resp_rdata_a, 32'h00000005);

      // misaligned handling; word 25 gets a distinctive upper half
      run_req(3'd7, 32'd100, 32'h8001000E);
      run_req(3'd1, 32'h67, 32'd0);
      chk("lh67_lat", lat, 32'd1);
      chk("lh67_err", {31'd0, resp_err_a}, 32'd1);
      chk("lh67_rdata", resp_rdata_a, 32'd0);
      chk("lh67_no_read", {31'd0, saw_rd}, 32'd0);
      chk("lh67_no_write", {31'd0, saw_wr}, 32'd0);
      chk("lh67_na_valid", {31'd0, resp_valid_b}, 32'd1);
      chk("lh67_na_err", {31'd0, resp_err_b}, 32'd0);
      chk("lh67_na_rdata", resp_rdata_b, 32'hFFFF8001);
      run_req(3'd2, 32'h66, 32'd0);
      chk("lw66_err", {31'd0, resp_err_a}, 32'd1);
      run_req(3'd7, 32'h6A, 32'hDEADBEEF);
      chk("sw6a_err", {31'd0, resp_err_a}, 32'd1);
      chk("sw6a_mem26", mem_a[26], 32'h0000AB05);
      chk("sw6a_no_write", {31'd0, saw_wr}, 32'd0);

      // SH upper halfword
      run_req(3'd6, 32'h6A, 32'h1234CAFE);
      chk("sh_lat", lat, 32'd2);
      chk("sh_err", {31'd0, resp_err_a}, 32'd0);
      chk("sh_mem26", mem_a[26], 32'hCAFEAB05);

      // back-to-back: LW presented in the SW response cycle
      @(negedge clk);
      req_op = 3'd7; req_addr = 32'd0; req_wdata = 32'h12345678; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1 req_op = 3'd2; req_addr = 32'd0; req_wdata = 32'd0; req_valid = 1'b1;
      @(negedge clk);
      chk("b2b_sw_valid", {31'd0, resp_valid_a}, 32'd1);
      chk("b2b_ready", {31'd0, req_ready_a}, 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("b2b_lw_reading", {31'd0, mem_read_a}, 32'd1);
      chk("b2b_mem0", mem_a[0], 32'h12345678);
      @(negedge clk);
      chk("b2b_lw_valid", {31'd0, resp_valid_a}, 32'd1);
      chk("b2b_lw_rdata", resp_rdata_a, 32'h12345678);

      // reset during ST_WR of SH 0x68
      @(negedge clk);
      req_op = 3'd6; req_addr = 32'h68; req_wdata = 32'h0000BEEF; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rmw_in_st_wr", {31'd0, mem_write_a}, 32'd1);
      chk("rmw_address", address_a, 32'h68);
      chk("rmw_write_data", write_data_a, 32'hCAFEBEEF);
      #1 reset = 1'b1;
      #1 chk("async_wr_drop", {31'd0, mem_write_a}, 32'd0);
      @(negedge clk);
      chk("abort_mem26", mem_a[26], 32'hCAFEAB05);
      chk("abort_no_resp", {31'd0, resp_valid_a}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_idle", {31'd0, req_ready_a}, 32'd1);
      chk("abort_still_no_resp", {31'd0, resp_valid_a}, 32'd0);
      run_req(3'd4, 32'h6A, 32'd0);
      chk("post_rst_lhu", resp_rdata_a, 32'h0000CAFE);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
